linreg_stream: RTL
==================

# linreg_stream

Parametrised, sequential linear-regression evaluator: computes s = bias + Σ w[i]·x[i] over N_FEAT features. Features arrive one per beat on a valid/ready stream, and weights and bias are loaded at run time through a register write port. Results leave on a valid/ready output stream with a per-sample overflow flag. It generalises the single-input combinational regression unit to multiple features, programmable coefficients and flow control.

## Interface
- IN_W, 16, feature width (unsigned)
- W_W, 16, weight and bias width (unsigned)
- N_FEAT, 4, features per sample (≥1)
- ACC_W, 32, result width (≥ IN_W+W_W)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset: one clock; asynchronous, active-low
- w_we  in  1  coefficient write strobe
- w_addr  in  $clog2(N_FEAT+1)  0..N_FEAT-1 selects weight i; N_FEAT selects bias
- w_data  in  W_W  coefficient value
- in_valid  in  1  feature beat valid
- in_ready  out  1  block can accept a feature
- in_data  in  IN_W  feature x[i], in index order 0..N_FEAT-1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  result s, modulo 2^ACC_W
- out_ovf  out  1  result wrapped during this sample

## Operation
- Storage: N_FEAT weight registers plus a bias register, all reset to 0.
  - A write with w_we=1 and a valid address updates the selected register on the clock edge.
  - A write to an address above N_FEAT is ignored.
- Feature counter idx (0..N_FEAT-1) and an ACC_W+1-bit accumulator acc with a sticky carry bit.
- FSM states: ACC and HOLD; reset state is ACC.
- ACC:
  - in_ready=1.
  - On accept (in_valid & in_ready): acc += w[idx]·in_data, zero-extended to ACC_W; sticky carry set if the sum exceeds 2^ACC_W-1; idx++.
  - On accept with idx=N_FEAT-1: out_data <= acc + w[idx]·in_data + bias, wrapped; out_ovf <= sticky carry OR any carry in this final add; acc and sticky cleared; idx <= 0; go to HOLD.
- HOLD:
  - in_ready=0; out_valid=1; out_data and out_ovf stable.
  - On out_ready: out_valid <= 0 and go to ACC.
- Coefficient write in the same cycle as an accept that reads that coefficient: the accept uses the old value, and the new value applies from the next beat.
- Bias is sampled only on the final-feature beat.
- Weight writes are legal in any state and never stall the stream.
- Product width is IN_W+W_W. The accumulator keeps one guard bit per add for carry detection; out_data is the low ACC_W bits.

## Timing
- Reset values: in_ready=0 while rst_n low; out_valid=0, out_data=0, out_ovf=0, idx=0, acc=0, all coefficients 0; in_ready=1 in the first cycle after release.
- Latency: out_valid rises the cycle after the final feature is accepted.
- Throughput: N_FEAT+1 cycles per sample with out_ready held high. The HOLD cycle is the bubble.
- Handshake rules:
  - Transfers occur only when valid and ready are both high on a clock edge.
  - out_data and out_valid hold while out_ready=0, for any number of cycles.
  - in_valid may drop between beats; idx holds.
- Reset mid-sample: the partial accumulation is discarded and coefficients return to 0. The next sample starts at idx=0.
- Reset asserted while in HOLD: the result is lost and out_valid drops asynchronously.

## Test plan
- **Basic sum.** Write w={1,2,3,4}, bias=10, then stream x={1,1,1,1} -> out_data=20, out_ovf=0, out_valid one cycle after the 4th accept.
- **Backpressure.** Same weights, x={10,20,30,40}, out_ready=0 for 5 cycles -> out_data=310 held stable, in_ready=0 throughout, and in_ready=1 the cycle after the handshake.
- **Overflow.** All weights=65535, bias=0, x all 65535 -> out_data=4294443012, out_ovf=1. The next sample with x={1,0,0,0} -> out_data=65535, out_ovf=0.
- **Write/accept collision.** w[1]=5, then write w[1]=7 in the same cycle as x[1]=2 is accepted, all other weights and x = 0 -> result 10. The next sample with x[1]=2 -> 14.
- **Reset mid-sample.** Accept 2 features, pulse rst_n low between clock edges -> out_valid=0 and in_ready=0 immediately. After release, with coefficients reprogrammed to w={1,1,1,1}, bias=0, x={1,2,3,4} -> out_data=10.
- **Gapped input.** in_valid toggling every other cycle with w={1,2,3,4}, bias=10, x={1,1,1,1} -> out_data=20, idx holds on idle cycles.

Source files
------------

// File: rtl/linreg_stream.sv
// ---------------------------------------------------------------------------
// linreg_stream
//
// Sequential linear-regression evaluator. Computes
//     s = bias + sum_{i=0}^{N_FEAT-1} w[i] * x[i]
// with features x[i] arriving one per beat on a valid/ready input stream.
// The weights and the bias are programmable at run time through a simple
// register write port. Each result leaves on a valid/ready output stream.
// The result is taken modulo 2^ACC_W and carries a flag that records whether
// any add for that sample wrapped.
//
// Parameters
//   IN_W    feature width (unsigned)
//   W_W     weight / bias width (unsigned)
//   N_FEAT  features per sample (>= 1)
//   ACC_W   result width (>= IN_W + W_W)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   w_we       coefficient write strobe
//   w_addr     0..N_FEAT-1 selects weight i, N_FEAT selects the bias,
//              higher addresses are ignored
//   w_data     coefficient value
//   in_valid   feature beat valid
//   in_ready   block can accept a feature (low while in reset)
//   in_data    feature x[i], delivered in index order 0..N_FEAT-1
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   result s, modulo 2^ACC_W
//   out_ovf    the result wrapped at some point during this sample
// ---------------------------------------------------------------------------
module linreg_stream #(
    parameter int IN_W   = 16,
    parameter int W_W    = 16,
    parameter int N_FEAT = 4,
    parameter int ACC_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          w_we,
    input  logic [$clog2(N_FEAT+1)-1:0]   w_addr,
    input  logic [W_W-1:0]                w_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data,
    output logic                          out_ovf
);

    localparam int PROD_W = IN_W + W_W;
    localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state_q,    state_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [ACC_W-1:0]     acc_q,      acc_d;
    logic                 sticky_q,   sticky_d;
    logic [ACC_W-1:0]     out_data_q, out_data_d;
    logic                 out_ovf_q,  out_ovf_d;
    logic [W_W-1:0]       w_q [N_FEAT];
    logic [W_W-1:0]       w_d [N_FEAT];
    logic [W_W-1:0]       bias_q,     bias_d;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic [PROD_W-1:0]    prod;
    logic [ACC_W:0]       sum_acc;
    logic [ACC_W:0]       sum_bias;
    logic                 last_beat;

    // The product always reads the registered weight, so a write landing on
    // the same edge as the beat that uses it only affects later beats.
    // Each add keeps one guard bit so a wrap can be detected.
    assign prod      = PROD_W'(w_q[idx_q]) * PROD_W'(in_data);
    assign sum_acc   = {1'b0, acc_q} + (ACC_W+1)'(prod);
    assign sum_bias  = {1'b0, sum_acc[ACC_W-1:0]} + (ACC_W+1)'(bias_q);
    assign last_beat = (idx_q == IDX_W'(N_FEAT - 1));

    // -----------------------------------------------------------------------
    // Coefficient register file: weights 0..N_FEAT-1 and the bias at
    // address N_FEAT. Out-of-range addresses fall through untouched.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_FEAT; i++) begin
            w_d[i] = w_q[i];
        end
        bias_d = bias_q;
        if (w_we) begin
            if (int'(w_addr) == N_FEAT) begin
                bias_d = w_data;
            end else begin
                for (int i = 0; i < N_FEAT; i++) begin
                    if (int'(w_addr) == i) begin
                        w_d[i] = w_data;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control: ACC accumulates beats, HOLD presents the finished result until
    // the downstream takes it. HOLD is the one-cycle bubble per sample.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        unique case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    if (last_beat) begin
                        // Bias enters only here, on the final beat.
                        out_data_d = sum_bias[ACC_W-1:0];
                        out_ovf_d  = sticky_q | sum_acc[ACC_W] | sum_bias[ACC_W];
                        acc_d      = '0;
                        sticky_d   = 1'b0;
                        idx_d      = '0;
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d    = sum_acc[ACC_W-1:0];
                        sticky_d = sticky_q | sum_acc[ACC_W];
                        idx_d    = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // in_ready is gated by rst_n so that it reads low throughout reset and
    // rises in the first cycle after release. out_valid comes straight from
    // the state register so it falls asynchronously with reset.
    // -----------------------------------------------------------------------
    assign in_ready  = (state_q == ST_ACC) && rst_n;
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            idx_q      <= '0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            bias_q     <= '0;
            for (int i = 0; i < N_FEAT; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            bias_q     <= bias_d;
            for (int i = 0; i < N_FEAT; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

endmodule
